bram_port_arb: RTL and testbench
================================

BRAM_PORT_ARB -- requirements
Module: bram_port_arb

Interface
REQ-001 Parameter DATA_WIDTH, default 8: BRAM word width.
REQ-002 Parameter ADDR_WIDTH, default 4: BRAM address bits.
REQ-003 a_clk  in  1  clock for all logic; also clocks the shared BRAM port.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 req  in  2  per-requester access request; bit i belongs to requester i; held high until gnt[i].
REQ-006 wr  in  2  per-requester write (1) / read (0) qualifier; valid while req[i] is high.
REQ-007 addr  in  2*ADDR_WIDTH  per-requester address; slice i is [i*ADDR_WIDTH +: ADDR_WIDTH].
REQ-008 wdata  in  2*DATA_WIDTH  per-requester write data; slice i is [i*DATA_WIDTH +: DATA_WIDTH].
REQ-009 gnt  out  2  one-cycle acceptance pulse, one-hot or zero.
REQ-010 rvalid  out  2  one-cycle read-data-valid pulse, one-hot or zero.
REQ-011 rdata  out  DATA_WIDTH  read data, shared by both requesters, qualified by rvalid.
REQ-012 busy  out  1  high whenever the FSM is not IDLE.
REQ-013 mem_en, mem_wr  out  1 each  BRAM port enable and write strobe.
REQ-014 mem_addr, mem_wdata  out  ADDR_WIDTH / DATA_WIDTH  BRAM port address and write data.
REQ-015 mem_rdata  in  DATA_WIDTH  BRAM port read data; registered in the BRAM, valid one cycle after mem_en.

Function
REQ-016 All outputs shall be registered.
REQ-017 The FSM shall have three states: IDLE, ACCESS, RESP.
REQ-018 IDLE: no req -> stay. Any req -> select winner w, latch wr[w]/addr/wdata into mem_wr/mem_addr/mem_wdata, set mem_en=1 and gnt[w]=1, go ACCESS.
REQ-019 ACCESS: mem_en and gnt[w] high for exactly this cycle, then go RESP; req is ignored in this state.
REQ-020 RESP: mem_en=0, gnt=0; capture rdata<=mem_rdata and, if the transaction was a read, set rvalid[w]=1 for the next cycle; go IDLE; req is ignored in this state.
REQ-021 Read latency: req first high in cycle T (FSM in IDLE) -> gnt in T+1 -> rvalid and rdata in T+3.
REQ-022 A write produces gnt only; rvalid stays 0 and rdata holds its previous value.
REQ-023 Arbitration shall be round-robin.
REQ-024 If exactly one req bit is high, that requester wins.
REQ-025 If both req bits are high, the requester not granted last wins.
REQ-026 The last-winner pointer shall update on every grant.
REQ-027 Throughput shall be one transaction per 3 cycles; a new arbitration may occur in the same cycle rvalid is high.
REQ-028 A req dropped after latching but before gnt shall not abort the transaction; it completes normally.
REQ-029 mem_addr, mem_wr and mem_wdata shall hold their values outside ACCESS; only mem_en gates the BRAM.

Reset
REQ-030 While rst is high: FSM->IDLE; gnt, rvalid, mem_en, mem_wr, busy = 0; rdata, mem_addr, mem_wdata = 0; last-winner pointer = 1, so requester 0 wins the first tie.
REQ-031 rst asserted in ACCESS or RESP shall abandon the transaction, with no gnt or rvalid issued afterwards.
REQ-032 rst shall take priority over all other inputs.

Structure
REQ-033 Package bram_arb_pkg shall hold the FSM state encoding constants (IDLE=2'd0, ACCESS=2'd1, RESP=2'd2) and the requester count NREQ=2.
REQ-034 One sub-module, bram_arb_rr, shall implement the round-robin winner select (inputs: req, pointer; output: one-hot winner); the FSM and datapath stay in bram_port_arb.

Verification
REQ-035 The bench shall include a BRAM model with 1-cycle registered read.
REQ-036 Single write: req=01, wr=01, addr0=3, wdata0=8'hA5 -> gnt=01 one cycle later, mem_en=1, mem_wr=1, mem_addr=3, no rvalid.
REQ-037 Read-back: requester 1 reads addr 3 -> gnt=10 at T+1, rvalid=10 and rdata=8'hA5 at T+3.
REQ-038 Contention: req=11 held continuously, both reads -> grants alternate 01,10,01,10, starting with 01 after reset, spaced 3 cycles apart.
REQ-039 Reset mid-operation: rst pulsed during ACCESS of a read -> no rvalid; busy=0; next tie grants requester 0.
REQ-040 Early drop: req0 high one cycle only, read addr 5 (holding 8'h3C) -> gnt=01, rvalid=01 with rdata=8'h3C at T+3.

Source files
------------

// File: rtl/bram_arb_pkg.sv
// Shared FSM state encoding and requester count for the BRAM port arbiter.
package bram_arb_pkg;
  localparam int unsigned NREQ = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;
endpackage

// File: rtl/bram_arb_rr.sv
// Round-robin winner select: a lone requester wins; on a tie the one not granted last wins.
module bram_arb_rr
  import bram_arb_pkg::*;
(
  input  logic [NREQ-1:0] req,
  input  logic            ptr,
  output logic [NREQ-1:0] win
);

  always_comb begin
    win = '0;
    case (req)
      2'b01:   win = 2'b01;
      2'b10:   win = 2'b10;
      2'b11:   win = ptr ? 2'b01 : 2'b10;
      default: win = '0;
    endcase
  end

endmodule

// File: rtl/bram_port_arb.sv
// Two-requester arbiter sharing one BRAM port; one transaction every three cycles.
module bram_port_arb
  import bram_arb_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                       a_clk,
  input  logic                       rst,
  input  logic [NREQ-1:0]            req,
  input  logic [NREQ-1:0]            wr,
  input  logic [2*ADDR_WIDTH-1:0]    addr,
  input  logic [2*DATA_WIDTH-1:0]    wdata,
  output logic [NREQ-1:0]            gnt,
  output logic [NREQ-1:0]            rvalid,
  output logic [DATA_WIDTH-1:0]      rdata,
  output logic                       busy,
  output logic                       mem_en,
  output logic                       mem_wr,
  output logic [ADDR_WIDTH-1:0]      mem_addr,
  output logic [DATA_WIDTH-1:0]      mem_wdata,
  input  logic [DATA_WIDTH-1:0]      mem_rdata
);

  state_t                state, state_n;
  logic                  last, last_n;
  logic [NREQ-1:0]       win;
  logic                  widx;
  logic [NREQ-1:0]       gnt_n, rvalid_n;
  logic [DATA_WIDTH-1:0] rdata_n, mem_wdata_n;
  logic [ADDR_WIDTH-1:0] mem_addr_n;
  logic                  mem_en_n, mem_wr_n, busy_n;

  bram_arb_rr u_rr (
    .req (req),
    .ptr (last),
    .win (win)
  );

  assign widx = win[1];

  // The last-winner pointer doubles as the owner of the in-flight transaction.
  always_comb begin
    state_n     = state;
    last_n      = last;
    gnt_n       = '0;
    rvalid_n    = '0;
    mem_en_n    = 1'b0;
    rdata_n     = rdata;
    mem_wr_n    = mem_wr;
    mem_addr_n  = mem_addr;
    mem_wdata_n = mem_wdata;
    case (state)
      IDLE: begin
        if (|req) begin
          state_n     = ACCESS;
          last_n      = widx;
          gnt_n       = win;
          mem_en_n    = 1'b1;
          mem_wr_n    = wr[widx];
          mem_addr_n  = widx ? addr[ADDR_WIDTH +: ADDR_WIDTH] : addr[0 +: ADDR_WIDTH];
          mem_wdata_n = widx ? wdata[DATA_WIDTH +: DATA_WIDTH] : wdata[0 +: DATA_WIDTH];
        end
      end
      ACCESS: state_n = RESP;
      RESP: begin
        state_n = IDLE;
        if (!mem_wr) begin
          rdata_n  = mem_rdata;
          rvalid_n = last ? 2'b10 : 2'b01;
        end
      end
      default: state_n = IDLE;
    endcase
    busy_n = (state_n != IDLE);
  end

  always_ff @(posedge a_clk) begin
    if (rst) begin
      state     <= IDLE;
      last      <= 1'b1;
      gnt       <= '0;
      rvalid    <= '0;
      rdata     <= '0;
      busy      <= 1'b0;
      mem_en    <= 1'b0;
      mem_wr    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      state     <= state_n;
      last      <= last_n;
      gnt       <= gnt_n;
      rvalid    <= rvalid_n;
      rdata     <= rdata_n;
      busy      <= busy_n;
      mem_en    <= mem_en_n;
      mem_wr    <= mem_wr_n;
      mem_addr  <= mem_addr_n;
      mem_wdata <= mem_wdata_n;
    end
  end

endmodule

// File: tb/tb_bram_port_arb.sv
// Bench for bram_port_arb: directed vector table, hand sequences, randomized run vs transaction model.
module tb_bram_port_arb;

  localparam int RN = 3000;

  logic       a_clk, rst;
  logic [1:0] req, wr, gnt, rvalid;
  logic [7:0] addr;
  logic [15:0] wdata;
  logic [7:0] rdata, mem_wdata, mem_rdata;
  logic [3:0] mem_addr;
  logic       busy, mem_en, mem_wr;

  int n_cmp = 0;
  int n_bad = 0;

  bram_port_arb #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) dut (
    .a_clk     (a_clk),
    .rst       (rst),
    .req       (req),
    .wr        (wr),
    .addr      (addr),
    .wdata     (wdata),
    .gnt       (gnt),
    .rvalid    (rvalid),
    .rdata     (rdata),
    .busy      (busy),
    .mem_en    (mem_en),
    .mem_wr    (mem_wr),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  initial a_clk = 1'b0;
  always #5 a_clk = ~a_clk;

  // BRAM with registered (read-first) 1-cycle read
  logic [7:0] bram [16];
  always_ff @(posedge a_clk) begin
    if (mem_en) begin
      if (mem_wr) bram[mem_addr] <= mem_wdata;
      mem_rdata <= bram[mem_addr];
    end
  end

  task automatic tick;
    @(posedge a_clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic do_reset;
    rst = 1'b1; req = '0; wr = '0; addr = '0; wdata = '0;
    tick; tick;
    rst = 1'b0;
  endtask

  typedef struct {
    logic [1:0] req, wr;
    logic [3:0] a0, a1;
    logic [7:0] d0, d1;
    logic [1:0] egnt, erv;
    logic [7:0] erd;
  } vec_t;

  vec_t vt [7];

  // reference model state for the random run
  logic [7:0] ref_mem [16];
  logic [1:0] eg [RN+4];
  logic [1:0] erv [RN+4];
  logic [7:0] erd [RN+4];
  logic       eb [RN+4];
  logic [3:0] ema [RN+4];
  logic       emw [RN+4];
  logic       pend [2];
  logic       pwr [2];
  logic [3:0] pa [2];
  logic [7:0] pd [2];

  initial begin
    vt[0] = '{req:2'b01, wr:2'b01, a0:4'd3, a1:4'd0, d0:8'hA5, d1:8'h00, egnt:2'b01, erv:2'b00, erd:8'h00};
    vt[1] = '{req:2'b10, wr:2'b00, a0:4'd0, a1:4'd3, d0:8'h00, d1:8'h00, egnt:2'b10, erv:2'b10, erd:8'hA5};
    vt[2] = '{req:2'b10, wr:2'b10, a0:4'd0, a1:4'd5, d0:8'h00, d1:8'h3C, egnt:2'b10, erv:2'b00, erd:8'hA5};
    vt[3] = '{req:2'b01, wr:2'b00, a0:4'd5, a1:4'd0, d0:8'h00, d1:8'h00, egnt:2'b01, erv:2'b01, erd:8'h3C};
    vt[4] = '{req:2'b11, wr:2'b00, a0:4'd3, a1:4'd5, d0:8'h00, d1:8'h00, egnt:2'b10, erv:2'b10, erd:8'h3C};
    vt[5] = '{req:2'b11, wr:2'b11, a0:4'd7, a1:4'd8, d0:8'h11, d1:8'h22, egnt:2'b01, erv:2'b00, erd:8'h3C};
    vt[6] = '{req:2'b11, wr:2'b00, a0:4'd8, a1:4'd7, d0:8'h00, d1:8'h00, egnt:2'b10, erv:2'b10, erd:8'h11};

    do_reset;
    chk("rst_gnt", gnt, 0);
    chk("rst_rvalid", rvalid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_mem_en", mem_en, 0);
    chk("rst_mem_wr", mem_wr, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);

    // each vector: req held one cycle only, transaction must still complete
    for (int i = 0; i < 7; i++) begin
      logic w;
      w = vt[i].egnt[1];
      req = vt[i].req; wr = vt[i].wr;
      addr = {vt[i].a1, vt[i].a0}; wdata = {vt[i].d1, vt[i].d0};
      tick;
      chk($sformatf("v%0d_gnt", i), gnt, vt[i].egnt);
      chk($sformatf("v%0d_mem_en", i), mem_en, 1);
      chk($sformatf("v%0d_mem_wr", i), mem_wr, vt[i].wr[w]);
      chk($sformatf("v%0d_mem_addr", i), mem_addr, w ? vt[i].a1 : vt[i].a0);
      if (vt[i].wr[w]) chk($sformatf("v%0d_mem_wdata", i), mem_wdata, w ? vt[i].d1 : vt[i].d0);
      chk($sformatf("v%0d_busy1", i), busy, 1);
      req = '0;
      tick;
      chk($sformatf("v%0d_gnt2", i), gnt, 0);
      chk($sformatf("v%0d_mem_en2", i), mem_en, 0);
      chk($sformatf("v%0d_rvalid2", i), rvalid, 0);
      chk($sformatf("v%0d_busy2", i), busy, 1);
      tick;
      chk($sformatf("v%0d_rvalid", i), rvalid, vt[i].erv);
      chk($sformatf("v%0d_rdata", i), rdata, vt[i].erd);
      chk($sformatf("v%0d_busy3", i), busy, 0);
    end

    // contention: both reading, req held; grants alternate every 3 cycles
    do_reset;
    req = 2'b11; wr = 2'b00; addr = {4'd5, 4'd3}; wdata = '0;
    for (int s = 1; s <= 12; s++) begin
      int k;
      tick;
      k = (s - 1) / 3;
      chk($sformatf("cont_gnt_s%0d", s), gnt, (s % 3 == 1) ? ((k % 2 == 0) ? 2'b01 : 2'b10) : 2'b00);
      if (s % 3 == 0) begin
        k = s / 3 - 1;
        chk($sformatf("cont_rvalid_s%0d", s), rvalid, (k % 2 == 0) ? 2'b01 : 2'b10);
        chk($sformatf("cont_rdata_s%0d", s), rdata, (k % 2 == 0) ? 8'hA5 : 8'h3C);
      end else begin
        chk($sformatf("cont_rvalid_s%0d", s), rvalid, 0);
      end
    end

    // reset during ACCESS of a read after requester 0 won
    req = '0;
    tick;
    req = 2'b01; wr = 2'b00; addr = {4'd0, 4'd5};
    tick;
    chk("mid_gnt", gnt, 2'b01);
    rst = 1'b1; req = '0;
    tick;
    rst = 1'b0;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_gnt", gnt, 0);
    chk("mid_rst_mem_en", mem_en, 0);
    for (int s = 0; s < 3; s++) begin
      tick;
      chk($sformatf("mid_rvalid_%0d", s), rvalid, 0);
      chk($sformatf("mid_busy_%0d", s), busy, 0);
      chk($sformatf("mid_gnt_%0d", s), gnt, 0);
    end
    req = 2'b11; addr = {4'd3, 4'd5};
    tick;
    chk("mid_tie_gnt", gnt, 2'b01);
    req = '0;
    tick; tick;
    chk("mid_tie_rvalid", rvalid, 2'b01);
    chk("mid_tie_rdata", rdata, 8'h3C);

    // randomized run against transaction-level model
    do_reset;
    for (int i = 0; i < 16; i++) ref_mem[i] = bram[i];
    for (int i = 0; i < RN + 4; i++) begin
      eg[i] = '0; erv[i] = '0; erd[i] = '0; eb[i] = 1'b0; ema[i] = '0; emw[i] = 1'b0;
    end
    for (int i = 0; i < 2; i++) begin
      pend[i] = 1'b0; pwr[i] = 1'b0; pa[i] = '0; pd[i] = '0;
    end
    begin
      int   idle_at;
      logic rlast;
      logic [7:0] hold;
      idle_at = 0; rlast = 1'b1; hold = 8'h00;
      for (int c = 0; c < RN; c++) begin
        int w;
        for (int i = 0; i < 2; i++) begin
          if (!pend[i] && $urandom_range(0, 2) == 0) begin
            pend[i] = 1'b1;
            pwr[i]  = 1'($urandom_range(0, 1));
            pa[i]   = 4'($urandom_range(0, 15));
            pd[i]   = 8'($urandom_range(0, 255));
          end
        end
        req = {pend[1], pend[0]}; wr = {pwr[1], pwr[0]};
        addr = {pa[1], pa[0]}; wdata = {pd[1], pd[0]};
        if (c >= idle_at && (pend[0] || pend[1])) begin
          if (pend[0] && pend[1]) w = rlast ? 0 : 1;
          else w = pend[1] ? 1 : 0;
          rlast = (w == 1);
          eg[c+1] = (w == 1) ? 2'b10 : 2'b01;
          eb[c+1] = 1'b1; eb[c+2] = 1'b1;
          ema[c+1] = pa[w]; emw[c+1] = pwr[w];
          idle_at = c + 3;
          if (pwr[w]) ref_mem[pa[w]] = pd[w];
          else begin
            erv[c+3] = (w == 1) ? 2'b10 : 2'b01;
            erd[c+3] = ref_mem[pa[w]];
          end
          pend[w] = 1'b0;
        end
        tick;
        if (erv[c+1] != 0) hold = erd[c+1];
        chk("rnd_gnt", gnt, eg[c+1]);
        chk("rnd_rvalid", rvalid, erv[c+1]);
        chk("rnd_rdata", rdata, hold);
        chk("rnd_busy", busy, eb[c+1]);
        chk("rnd_mem_en", mem_en, (eg[c+1] != 0));
        if (eg[c+1] != 0) begin
          chk("rnd_mem_addr", mem_addr, ema[c+1]);
          chk("rnd_mem_wr", mem_wr, emw[c+1]);
        end
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
